// File: rtl/iq_modulator.sv
// Baseband I/Q modulator: maps BPSK/QPSK/Gray 16-QAM symbols, zero-stuffs by SPS and
// pulse-shapes each rail with a shared, runtime-loadable NTAPS-tap FIR, advanced by en.

module iq_modulator #(
  parameter int unsigned SPS   = 8,
  parameter int unsigned NTAPS = 32,
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned ACCW  = 40,
  localparam int unsigned AW   = $clog2(NTAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic                 sym_valid,
  input  logic [3:0]           sym_bits,
  output logic                 sym_ready,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic signed [DW-1:0] real_out,
  output logic signed [DW-1:0] imag_out,
  output logic                 out_valid,
  output logic                 underrun
);

  localparam int unsigned PW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [PW-1:0] PhaseLast = PW'(SPS - 1);

  localparam logic signed [DW-1:0]   PskLvl    = {2'b01, {(DW - 2){1'b0}}};
  localparam logic signed [DW-1:0]   QamLvl1   = {4'b0001, {(DW - 4){1'b0}}};
  localparam logic signed [DW-1:0]   QamLvl3   = {4'b0011, {(DW - 4){1'b0}}};
  localparam logic signed [CW-1:0]   CoefUnity = {1'b0, {(CW - 1){1'b1}}};
  localparam logic signed [ACCW-1:0] AccMax    = {{(ACCW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACCW-1:0] AccMin    = {{(ACCW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  function automatic logic signed [DW-1:0] psk_map(input logic b);
    return b ? -PskLvl : PskLvl;
  endfunction

  function automatic logic signed [DW-1:0] qam_map(input logic [1:0] gray);
    logic signed [DW-1:0] lvl;
    unique case (gray)
      2'b00:   lvl = -QamLvl3;
      2'b01:   lvl = -QamLvl1;
      2'b11:   lvl = QamLvl1;
      default: lvl = QamLvl3;
    endcase
    return lvl;
  endfunction

  function automatic logic signed [ACCW-1:0] mac_term(input logic signed [DW-1:0] x,
                                                      input logic signed [CW-1:0] c);
    logic signed [ACCW-1:0] xe;
    logic signed [ACCW-1:0] ce;
    xe = {{(ACCW - DW){x[DW-1]}}, x};
    ce = {{(ACCW - CW){c[CW-1]}}, c};
    return xe * ce;
  endfunction

  function automatic logic signed [DW-1:0] sat_out(input logic signed [ACCW-1:0] v);
    if (v > AccMax) return AccMax[DW-1:0];
    if (v < AccMin) return AccMin[DW-1:0];
    return v[DW-1:0];
  endfunction

  logic [PW-1:0]        phase_q, phase_d;
  logic                 underrun_q, underrun_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] real_q, real_d;
  logic signed [DW-1:0] imag_q, imag_d;

  // History holds the previous NTAPS-1 inputs; tap 0 is the sample entering this cycle.
  logic signed [DW-1:0] hist_re_q [NTAPS-1];
  logic signed [DW-1:0] hist_re_d [NTAPS-1];
  logic signed [DW-1:0] hist_im_q [NTAPS-1];
  logic signed [DW-1:0] hist_im_d [NTAPS-1];
  logic signed [CW-1:0] coef_q [NTAPS];
  logic signed [CW-1:0] coef_d [NTAPS];

  logic                   slot;
  logic                   take;
  logic signed [DW-1:0]   x_re, x_im;
  logic signed [ACCW-1:0] acc_re, acc_im;
  logic signed [ACCW-1:0] shf_re, shf_im;

  always_comb begin
    slot = en & (phase_q == '0);
    take = slot & sym_valid;
    x_re = '0;
    x_im = '0;
    if (take) begin
      unique case (mode)
        2'd0: x_re = psk_map(sym_bits[0]);
        2'd1: begin
          x_re = psk_map(sym_bits[1]);
          x_im = psk_map(sym_bits[0]);
        end
        2'd2: begin
          x_re = qam_map(sym_bits[3:2]);
          x_im = qam_map(sym_bits[1:0]);
        end
        default: ;  // reserved mode: the slot is consumed but carries a zero
      endcase
    end
  end

  assign sym_ready = slot;

  always_comb begin
    phase_d     = phase_q;
    out_valid_d = en;
    underrun_d  = underrun_q | (slot & ~sym_valid);
    if (en) begin
      phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
    end
  end

  always_comb begin
    hist_re_d = hist_re_q;
    hist_im_d = hist_im_q;
    if (en) begin
      hist_re_d[0] = x_re;
      hist_im_d[0] = x_im;
      for (int k = 1; k < int'(NTAPS) - 1; k++) begin
        hist_re_d[k] = hist_re_q[k-1];
        hist_im_d[k] = hist_im_q[k-1];
      end
    end
  end

  always_comb begin
    acc_re = mac_term(x_re, coef_q[0]);
    acc_im = mac_term(x_im, coef_q[0]);
    for (int k = 1; k < int'(NTAPS); k++) begin
      acc_re = acc_re + mac_term(hist_re_q[k-1], coef_q[k]);
      acc_im = acc_im + mac_term(hist_im_q[k-1], coef_q[k]);
    end
    shf_re = acc_re >>> (CW - 1);
    shf_im = acc_im >>> (CW - 1);
    real_d = real_q;
    imag_d = imag_q;
    if (en) begin
      real_d = sat_out(shf_re);
      imag_d = sat_out(shf_im);
    end
  end

  // Writes land at the edge, so a computation in the write cycle still sees the old tap.
  always_comb begin
    coef_d = coef_q;
    for (int k = 0; k < int'(NTAPS); k++) begin
      if (coef_we && (coef_addr == AW'(k))) begin
        coef_d[k] = coef_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q     <= '0;
      underrun_q  <= 1'b0;
      out_valid_q <= 1'b0;
      real_q      <= '0;
      imag_q      <= '0;
      for (int k = 0; k < int'(NTAPS) - 1; k++) begin
        hist_re_q[k] <= '0;
        hist_im_q[k] <= '0;
      end
      for (int k = 0; k < int'(NTAPS); k++) begin
        coef_q[k] <= (k == 0) ? CoefUnity : '0;
      end
    end else begin
      phase_q     <= phase_d;
      underrun_q  <= underrun_d;
      out_valid_q <= out_valid_d;
      real_q      <= real_d;
      imag_q      <= imag_d;
      hist_re_q   <= hist_re_d;
      hist_im_q   <= hist_im_d;
      coef_q      <= coef_d;
    end
  end

  assign real_out  = real_q;
  assign imag_out  = imag_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_iq_modulator.sv
// Bench for iq_modulator: directed scenarios with literal expectations plus a randomized
// run, all checked every cycle against a sample-history reference model.

module tb_iq_modulator;

  localparam int SPS   = 8;
  localparam int NTAPS = 32;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int ACCW  = 40;
  localparam int AW    = $clog2(NTAPS);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [1:0]           mode;
  logic                 sym_valid;
  logic [3:0]           sym_bits;
  logic                 sym_ready;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic signed [DW-1:0] real_out;
  logic signed [DW-1:0] imag_out;
  logic                 out_valid;
  logic                 underrun;

  iq_modulator #(
    .SPS  (SPS),
    .NTAPS(NTAPS),
    .DW   (DW),
    .CW   (CW),
    .ACCW (ACCW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sym_valid(sym_valid),
    .sym_bits (sym_bits),
    .sym_ready(sym_ready),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .real_out (real_out),
    .imag_out (imag_out),
    .out_valid(out_valid),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) begin
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  // Reference model: explicit sample history, plain multiply-accumulate.
  longint m_coef [NTAPS];
  longint hx_re  [NTAPS];
  longint hx_im  [NTAPS];
  int     m_phase;
  longint e_re;
  longint e_im;
  logic   e_valid;
  logic   e_under;

  function automatic longint lvl_psk(input logic b);
    longint h;
    h = longint'(1) << (DW - 2);
    return b ? -h : h;
  endfunction

  function automatic longint lvl_qam(input logic [1:0] g);
    longint l;
    l = longint'(1) << (DW - 4);
    case (g)
      2'b00:   return -3 * l;
      2'b01:   return -l;
      2'b11:   return l;
      default: return 3 * l;
    endcase
  endfunction

  function automatic longint clip(input longint v);
    longint hi;
    longint lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_edge();
    longint xr, xi, sr, si;
    if (!rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        m_coef[k] = (k == 0) ? (longint'(1) << (CW - 1)) - 1 : 0;
        hx_re[k]  = 0;
        hx_im[k]  = 0;
      end
      m_phase = 0;
      e_re    = 0;
      e_im    = 0;
      e_valid = 1'b0;
      e_under = 1'b0;
    end else begin
      e_valid = en;
      if (en) begin
        xr = 0;
        xi = 0;
        if (m_phase == 0) begin
          if (!sym_valid) begin
            e_under = 1'b1;
          end else begin
            case (mode)
              2'd0: xr = lvl_psk(sym_bits[0]);
              2'd1: begin
                xr = lvl_psk(sym_bits[1]);
                xi = lvl_psk(sym_bits[0]);
              end
              2'd2: begin
                xr = lvl_qam(sym_bits[3:2]);
                xi = lvl_qam(sym_bits[1:0]);
              end
              default: ;
            endcase
          end
        end
        for (int k = NTAPS - 1; k > 0; k--) begin
          hx_re[k] = hx_re[k-1];
          hx_im[k] = hx_im[k-1];
        end
        hx_re[0] = xr;
        hx_im[0] = xi;
        sr = 0;
        si = 0;
        for (int k = 0; k < NTAPS; k++) begin
          sr += m_coef[k] * hx_re[k];
          si += m_coef[k] * hx_im[k];
        end
        e_re    = clip(sr >>> (CW - 1));
        e_im    = clip(si >>> (CW - 1));
        m_phase = (m_phase + 1) % SPS;
      end
      if (coef_we && (int'(coef_addr) < NTAPS)) begin
        m_coef[coef_addr] = longint'(coef_data);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    model_edge();
    forever begin
      @(negedge clk);
      chk("real_out", real_out, e_re);
      chk("imag_out", imag_out, e_im);
      chk("out_valid", out_valid, e_valid);
      chk("underrun", underrun, e_under);
      chk("sym_ready", sym_ready, (en && (m_phase == 0)) ? 1 : 0);
      @(posedge clk);
      model_edge();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic e, input logic [1:0] m, input logic v, input logic [3:0] b);
    en        = e;
    mode      = m;
    sym_valid = v;
    sym_bits  = b;
    coef_we   = 1'b0;
  endtask

  task automatic wr_coef(input int a, input int v);
    set_in(1'b0, 2'd0, 1'b0, 4'd0);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(v);
    step();
    coef_we = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    set_in(1'b0, 2'd0, 1'b0, 4'd0);
    coef_addr = '0;
    coef_data = '0;
    step();
    step();
    chk("rst_real", real_out, 0);
    chk("rst_imag", imag_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b1;
    step();

    // QPSK 00 with default unity tap 0
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < SPS; p++) begin
        set_in(1'b1, 2'd1, 1'b1, 4'b0000);
        #1;
        chk("qpsk_ready", sym_ready, (p == 0) ? 1 : 0);
        step();
        chk("qpsk_re", real_out, (p == 0) ? 16383 : 0);
        chk("qpsk_im", imag_out, (p == 0) ? 16383 : 0);
        chk("qpsk_valid", out_valid, 1);
        if (s == 0 && p == 0) chk("model_pin_qpsk", e_re, 16383);
      end
    end
    chk("qpsk_underrun", underrun, 0);

    // BPSK through a four-tap ramp
    wr_coef(0, 1000);
    wr_coef(1, 2000);
    wr_coef(2, 3000);
    wr_coef(3, 4000);
    for (int p = 0; p < SPS; p++) begin
      set_in(1'b1, 2'd0, 1'b1, 4'b0000);
      step();
      if (p < 4) begin
        chk("bpsk_re", real_out, 500 * (p + 1));
        chk("bpsk_im", imag_out, 0);
      end
    end

    // 16-QAM with default taps restored
    wr_coef(0, 32767);
    wr_coef(1, 0);
    wr_coef(2, 0);
    wr_coef(3, 0);
    for (int p = 0; p < SPS; p++) begin
      set_in(1'b1, 2'd2, 1'b1, 4'b1001);
      step();
      if (p == 0) begin
        chk("qam_re", real_out, 12287);
        chk("qam_im", imag_out, -4096);
        chk("model_pin_qam", e_im, -4096);
      end
    end

    // Saturation: three equal symbols line up on taps 0, 8, 16
    wr_coef(8, 32767);
    wr_coef(16, 32767);
    for (int s = 0; s < 6; s++) begin
      for (int p = 0; p < SPS; p++) begin
        set_in(1'b1, 2'd1, 1'b1, (s < 3) ? 4'b0000 : 4'b0011);
        step();
        if (p == 0 && s == 2) begin
          chk("sat_pos_re", real_out, 32767);
          chk("sat_pos_im", imag_out, 32767);
          chk("model_pin_sat", e_re, 32767);
        end
        if (p == 0 && s == 5) begin
          chk("sat_neg_re", real_out, -32768);
          chk("sat_neg_im", imag_out, -32768);
        end
      end
    end

    // Underrun, then a stall with en low
    set_in(1'b1, 2'd1, 1'b0, 4'b0000);
    step();
    chk("underrun_set", underrun, 1);
    for (int p = 1; p < 4; p++) begin
      set_in(1'b1, 2'd1, 1'b1, 4'b0000);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 2'd1, 1'b1, 4'b0000);
      #1;
      chk("stall_ready", sym_ready, 0);
      step();
      chk("stall_valid", out_valid, 0);
      chk("stall_underrun", underrun, 1);
    end
    for (int p = 4; p < SPS; p++) begin
      set_in(1'b1, 2'd1, 1'b1, 4'b0000);
      #1;
      chk("resume_ready", sym_ready, 0);
      step();
    end
    for (int p = 0; p < SPS; p++) begin
      set_in(1'b1, 2'd1, 1'b1, 4'b0110);
      #1;
      chk("resume_ready", sym_ready, (p == 0) ? 1 : 0);
      step();
    end
    chk("underrun_held", underrun, 1);

    // Randomized traffic, coefficient writes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) != 0);
      en        = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom_range(0, 3));
      sym_valid = ($urandom_range(0, 7) != 0);
      sym_bits  = 4'($urandom_range(0, 15));
      coef_we   = ($urandom_range(0, 9) == 0);
      coef_addr = AW'($urandom_range(0, NTAPS - 1));
      if ($urandom_range(0, 3) == 0) coef_data = CW'($urandom());
      else coef_data = CW'($urandom_range(0, 8191) - 4096);
      step();
    end
    rst = 1'b1;
    coef_we = 1'b0;

    // Reset mid-symbol with non-default taps
    wr_coef(0, 5000);
    wr_coef(2, -7000);
    for (int p = 0; p < 3; p++) begin
      set_in(1'b1, 2'd1, 1'b1, 4'b0000);
      step();
    end
    rst = 1'b0;
    set_in(1'b1, 2'd1, 1'b1, 4'b0011);
    step();
    chk("midrst_re", real_out, 0);
    chk("midrst_im", imag_out, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_underrun", underrun, 0);
    rst = 1'b1;
    for (int p = 0; p < SPS; p++) begin
      set_in(1'b1, 2'd1, 1'b1, 4'b0000);
      #1;
      chk("postrst_ready", sym_ready, (p == 0) ? 1 : 0);
      step();
      chk("postrst_re", real_out, (p == 0) ? 16383 : 0);
      chk("postrst_im", imag_out, (p == 0) ? 16383 : 0);
    end

    set_in(1'b0, 2'd0, 1'b0, 4'd0);
    step();
    step();
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_modulator.md
# iq_modulator

Parametrised baseband modulator for the transmit path: accepts symbols through a valid/ready handshake, maps them to BPSK, QPSK or Gray-coded 16-QAM I/Q levels, zero-stuffs by SPS and pulse-shapes each rail with a runtime-loadable NTAPS-tap FIR. A sample-rate enable replaces clock gating, and symbol starvation is flagged instead of silently corrupting the output.

## Interface
- SPS, 8: samples per symbol (≥1)
- NTAPS, 32: FIR taps per rail (2..64)
- DW, 16: mapper level and output sample width, signed
- CW, 16: coefficient width, signed Q1.(CW-1)
- ACCW, 40: accumulator width; must be ≥ DW+CW+clog2(NTAPS)
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  sample-rate enable; one output sample per cycle with en=1
- mode  in  2  0 BPSK, 1 QPSK, 2 16-QAM, 3 reserved
- sym_valid  in  1  symbol offered
- sym_bits  in  4  symbol bits (BPSK uses [0], QPSK uses [1:0])
- sym_ready  out  1  symbol slot open this cycle
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NTAPS)  tap index
- coef_data  in  CW  signed coefficient
- real_out  out  DW  signed I sample
- imag_out  out  DW  signed Q sample
- out_valid  out  1  real_out/imag_out updated this cycle
- underrun  out  1  sticky: a symbol slot passed with no symbol

## Operation
- Phase counter 0..SPS-1 advances on each en=1 cycle and wraps SPS-1→0; holds while en=0.
- sym_ready = en & (phase==0), combinational. Handshake completes when sym_valid & sym_ready.
- Slot at phase 0: if sym_valid, the mapped symbol enters the filter and mode is sampled now; if not, zero enters and underrun sets. Phases 1..SPS-1 always insert zero.
- Levels: BPSK I = bit0 ? −2^(DW-2) : +2^(DW-2), Q = 0. QPSK I from bit1, Q from bit0, same mapping. 16-QAM I from [3:2], Q from [1:0], Gray: 00→−3L, 01→−L, 11→+L, 10→+3L, L = 2^(DW-4). Mode 3: symbol consumed, zero inserted, underrun unaffected.
- FIR per rail: NTAPS-deep delay line shifts on en; acc = Σ coef[k]·x[n−k] at full ACCW precision; result = acc >>> (CW−1) (arithmetic, floor), saturated to [−2^(DW-1), 2^(DW-1)−1]. Both rails share coefficients.
- Coefficient write: on any edge with coef_we=1 and coef_addr<NTAPS, independent of en; addr ≥ NTAPS ignored. The new value is used by the next en computation, including one in the same cycle as the write only from the following edge onward.
- en=0: delay lines, phase and outputs hold; out_valid=0; sym_ready=0.

## Timing
- Reset (rst=0 at an edge): phase=0, delay lines 0, real_out=imag_out=0, out_valid=0, underrun=0, coef[0]=2^(CW-1)−1, all other coefs 0. Applies mid-operation; in-flight symbols are discarded.
- Symbol accepted on en cycle t: contribution via coef[k] appears on the outputs registered at the edge ending en-cycle t+k, with out_valid=1 in the following cycle (latency 1 cycle at tap 0).
- out_valid is a registered copy of en (cleared by reset).
- underrun clears only on reset.
- Continuous en=1: exactly one symbol per SPS cycles; throughput independent of sym_valid.

## Test plan
- Reset defaults, SPS=8, QPSK, bits 2'b00 at phase 0, en=1 → next cycle real_out=imag_out=16383, out_valid=1, then seven cycles of 0/0; underrun stays 0 while symbols supplied every slot.
- Load coef[0..3]=1000,2000,3000,4000 (rest 0), BPSK bit 0 → real_out 500, 1000, 1500, 2000 on successive cycles, imag_out 0.
- 16-QAM bits 4'b1001, default coefs → real_out=12287, imag_out=−4096.
- coef[0]=coef[8]=coef[16]=32767, three QPSK 2'b00 symbols back-to-back → peak real_out saturates to 32767; repeat with 2'b11 → −32768.
- sym_valid=0 at a phase-0 slot → zero inserted, underrun=1 and held; then en=0 for 5 cycles → outputs hold, out_valid=0, sym_ready=0, phase frozen.
- rst=0 mid-symbol with non-default coefs → next cycle all outputs 0, underrun 0, coefs default; first post-reset QPSK 00 symbol gives 16383.
